mips_instr_mem_loader: RTL and testbench
========================================

# mips_instr_mem_loader

Instruction-side memory responder for the Harvard MIPS CPU: the far end of the CPU's instruction-fetch interface. A program is streamed in word by word over a valid/ready load port. The block then answers CPU fetches combinationally with byte-swapped instruction words from its reset-vector window. It also flags misaligned or out-of-window fetches and detects the CPU halt condition (jump to address 0 with `active` low).

## Interface
Parameters:
- `DEPTH_WORDS`, 64: program storage depth in 32-bit words (power of two, ≥2).
- `BASE_ADDR`, 32'hBFC00000: byte address of word 0 (reset vector).

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `clk_enable`  in  1  gates the fetch counter only; loading and halt detection ignore it.
- `load_valid`  in  1  load word present.
- `load_ready`  out  1  block accepts a load word this cycle.
- `load_word`  in  32  instruction in MIPS big-endian listing order.
- `load_last`  in  1  qualifies the final load word.
- `loaded`  out  1  program loaded; fetch port live.
- `load_count`  out  $clog2(DEPTH_WORDS)+1  words accepted.
- `instr_address`  in  32  CPU fetch byte address.
- `instr_readdata`  out  32  fetched word, byte-reversed for the CPU.
- `active`  in  1  CPU active flag.
- `addr_fault`  out  1  sticky: bad fetch seen while loaded.
- `done`  out  1  sticky: halt detected.
- `fetch_count`  out  32  valid fetch cycles counted.

## Operation
- FSM states are LOAD and RUN. Reset → LOAD.
- LOAD:
  - `load_ready`=1.
  - A handshake (`load_valid`&`load_ready`) writes `load_word` into `mem[wr_ptr]`, then increments `wr_ptr` and `load_count`.
  - LOAD→RUN on a handshake with `load_last`=1, or on a handshake at `wr_ptr`==DEPTH_WORDS-1 (full auto-terminate; extra words are never accepted).
- RUN:
  - `load_ready`=0 and `loaded`=1.
  - `load_valid` is ignored; memory is not written.
  - RUN exits only via reset.
- Fetch decode (combinational): offset = `instr_address` − BASE_ADDR.
  - The fetch is valid when state is RUN, offset[1:0]==0, and offset>>2 < `load_count`.
  - Valid: `instr_readdata` = {w[7:0],w[15:8],w[23:16],w[31:24]}, where w = mem[offset>>2].
  - Otherwise `instr_readdata` = 32'h00000000 (NOP). This includes address 0, which is the halt target, and words beyond `load_count` but inside the depth.
- `addr_fault`:
  - Set at the clock edge in RUN when the fetch is invalid, `instr_address`≠0, and `active`=1.
  - Sticky until reset.
- `done`:
  - Set at the clock edge in RUN when `instr_address`==0 and `active`==0.
  - Sticky until reset. Never set in LOAD.
- `fetch_count`:
  - Increments at the clock edge in RUN when `active`&`clk_enable` and the fetch is valid.
  - Wraps at 2^32.
  - Holds once `done`=1.
- Memory contents are not cleared by reset. Readback is masked by `load_count`, so stale data is never visible.

## Timing
- Reset values:
  - State LOAD, `load_ready`=1, `loaded`=0.
  - `load_count`=0, `wr_ptr`=0.
  - `addr_fault`=0, `done`=0, `fetch_count`=0.
  - `instr_readdata`=0.
- Load throughput is one word per cycle. `load_ready` is a function of state only and does not depend on `load_valid`.
- `loaded` rises the cycle after the final handshake; the fetch port is live in that same cycle.
- Fetch latency is zero: `instr_readdata` is combinational from `instr_address` and registered memory.
- `done`, `addr_fault` and `fetch_count` update one edge after the qualifying condition.
- Reset mid-load: the partial program is discarded (`load_count`=0), and a fresh load starts the next cycle.
- If reset and a handshake fall in the same cycle, reset wins and no write occurs.

## Test plan
1. Reset, then idle: `load_ready`=1, `loaded`=0, `instr_readdata`=0 for `instr_address`=BFC00000, and all sticky flags 0.
2. Stream 24846006, 24A50002, 00A41004, 00000008, 24000000 with `load_last` on the 5th word. Required response:
   - `loaded`=1 the next cycle and `load_count`=5.
   - BFC00000→06608424.
   - BFC00008→0410A400.
   - BFC00010→00000024.
3. After case 2:
   - BFC00014 (beyond `load_count`) → 0.
   - BFC00002 with `active`=1 → 0, and `addr_fault`=1 next cycle.
   - 00000000 with `active`=1 → 0, and no fault.
4. With DEPTH_WORDS=4, hold `load_valid` for 6 words and no `load_last`:
   - Exactly 4 words are accepted.
   - `loaded`=1 after the 4th.
   - `load_ready`=0 afterwards.
   - BFC0000C returns the swapped 4th word.
5. Drive RUN with 3 valid fetches at `active`=1 (`fetch_count`=3), then `instr_address`=0 with `active`=0:
   - `done`=1 next cycle.
   - `fetch_count` stays 3.
6. Reset after 2 words of a load, then reload 1 word with `load_last`:
   - `load_count`=1.
   - BFC00004→0.
   - `done`/`addr_fault` remain 0.

Source files
------------

// File: rtl/mips_instr_mem_loader_if.sv
// Load-port and instruction-fetch signal bundle between the loader/CPU side and the memory responder.
// The master side streams words and issues fetches. The slave side accepts loads and answers fetches.
interface mips_instr_mem_loader_if #(
    parameter int LOAD_CNT_W = 7
);
    logic                  clk_enable;
    logic                  load_valid;
    logic                  load_ready;
    logic [31:0]           load_word;
    logic                  load_last;
    logic                  loaded;
    logic [LOAD_CNT_W-1:0] load_count;
    logic [31:0]           instr_address;
    logic [31:0]           instr_readdata;
    logic                  active;
    logic                  addr_fault;
    logic                  done;
    logic [31:0]           fetch_count;

    modport master (
        output clk_enable, load_valid, load_word, load_last, instr_address, active,
        input  load_ready, loaded, load_count, instr_readdata, addr_fault, done, fetch_count
    );

    modport slave (
        input  clk_enable, load_valid, load_word, load_last, instr_address, active,
        output load_ready, loaded, load_count, instr_readdata, addr_fault, done, fetch_count
    );
endinterface

// File: rtl/mips_instr_mem_loader.sv
// Instruction memory: streams a program in, then serves byte-swapped words to the CPU and watches for halt.
// Latency: load takes one word per cycle; a fetch returns in zero cycles; the flags and fetch_count update one edge later.
// Backpressure: load_ready is high for the whole LOAD state and drops for good once the last or the DEPTH-th word is taken.
module mips_instr_mem_loader #(
    parameter int          DEPTH_WORDS = 64,
    parameter logic [31:0] BASE_ADDR   = 32'hBFC00000
) (
    input  logic                     clk,
    input  logic                     reset,
    mips_instr_mem_loader_if.slave   bus
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = AW + 1;

    typedef enum logic {S_LOAD, S_RUN} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   load_count_q, load_count_d;
    logic            addr_fault_q, addr_fault_d;
    logic            done_q, done_d;
    logic [31:0]     fetch_count_q, fetch_count_d;
    logic [31:0]     mem_q [DEPTH_WORDS];

    logic            mem_we;
    logic [31:0]     offset;
    logic            fetch_ok;
    logic [31:0]     rd_word;

    // The index is masked by load_count, so a fetch never reaches stale words left from before a reset.
    always_comb begin
        offset   = bus.instr_address - BASE_ADDR;
        fetch_ok = (state_q == S_RUN) && (offset[1:0] == 2'b00) &&
                   ({2'b00, offset[31:2]} < 32'(load_count_q));
        rd_word  = mem_q[offset[AW+1:2]];
    end

    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        load_count_d  = load_count_q;
        addr_fault_d  = addr_fault_q;
        done_d        = done_q;
        fetch_count_d = fetch_count_q;
        mem_we        = 1'b0;

        case (state_q)
            S_LOAD: begin
                if (bus.load_valid) begin
                    mem_we       = !reset;
                    wr_ptr_d     = wr_ptr_q + 1'b1;
                    load_count_d = load_count_q + 1'b1;
                    if (bus.load_last || (wr_ptr_q == AW'(DEPTH_WORDS - 1)))
                        state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!fetch_ok && (bus.instr_address != 32'd0) && bus.active)
                    addr_fault_d = 1'b1;
                if ((bus.instr_address == 32'd0) && !bus.active)
                    done_d = 1'b1;
                if (fetch_ok && bus.active && bus.clk_enable && !done_q)
                    fetch_count_d = fetch_count_q + 32'd1;
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_LOAD;
            wr_ptr_q      <= '0;
            load_count_q  <= '0;
            addr_fault_q  <= 1'b0;
            done_q        <= 1'b0;
            fetch_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            load_count_q  <= load_count_d;
            addr_fault_q  <= addr_fault_d;
            done_q        <= done_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            mem_q[wr_ptr_q] <= bus.load_word;
    end

    assign bus.load_ready     = (state_q == S_LOAD);
    assign bus.loaded         = (state_q == S_RUN);
    assign bus.load_count     = load_count_q;
    assign bus.addr_fault     = addr_fault_q;
    assign bus.done           = done_q;
    assign bus.fetch_count    = fetch_count_q;
    assign bus.instr_readdata = fetch_ok ? {rd_word[7:0], rd_word[15:8], rd_word[23:16], rd_word[31:24]}
                                         : 32'h0000_0000;
endmodule

// File: tb/tb_mips_instr_mem_loader.sv
// Directed bench for mips_instr_mem_loader: a 64-word instance for the main flow and a 4-word instance for auto-termination.
module tb_mips_instr_mem_loader;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   accepted;

    always #5 clk = ~clk;

    mips_instr_mem_loader_if #(.LOAD_CNT_W(7)) b ();
    mips_instr_mem_loader_if #(.LOAD_CNT_W(3)) b4 ();

    mips_instr_mem_loader #(.DEPTH_WORDS(64), .BASE_ADDR(32'hBFC00000)) dut (
        .clk(clk), .reset(reset), .bus(b)
    );
    mips_instr_mem_loader #(.DEPTH_WORDS(4), .BASE_ADDR(32'hBFC00000)) dut4 (
        .clk(clk), .reset(reset), .bus(b4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] a, input logic act);
        b.instr_address = a;
        b.active        = act;
        #1;
    endtask

    task automatic load1(input logic [31:0] w, input logic last);
        b.load_valid = 1'b1;
        b.load_word  = w;
        b.load_last  = last;
        tick();
        b.load_valid = 1'b0;
        b.load_last  = 1'b0;
    endtask

    initial begin
        b.clk_enable = 1'b1;  b.load_valid = 1'b0; b.load_word = 32'd0; b.load_last = 1'b0;
        b.instr_address = 32'hBFC00000; b.active = 1'b0;
        b4.clk_enable = 1'b1; b4.load_valid = 1'b0; b4.load_word = 32'd0; b4.load_last = 1'b0;
        b4.instr_address = 32'hBFC00000; b4.active = 1'b0;

        // reset and idle
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("rst_load_ready", 32'(b.load_ready), 32'd1);
        chk("rst_loaded", 32'(b.loaded), 32'd0);
        chk("rst_load_count", 32'(b.load_count), 32'd0);
        chk("rst_readdata", b.instr_readdata, 32'h0);
        chk("rst_fault", 32'(b.addr_fault), 32'd0);
        chk("rst_done", 32'(b.done), 32'd0);
        chk("rst_fetch_count", b.fetch_count, 32'd0);

        // five-word program with load_last on the fifth
        load1(32'h24846006, 1'b0);
        load1(32'h24A50002, 1'b0);
        load1(32'h00A41004, 1'b0);
        load1(32'h00000008, 1'b0);
        chk("pre_last_loaded", 32'(b.loaded), 32'd0);
        load1(32'h24000000, 1'b1);
        chk("prog_loaded", 32'(b.loaded), 32'd1);
        chk("prog_load_ready", 32'(b.load_ready), 32'd0);
        chk("prog_load_count", 32'(b.load_count), 32'd5);
        fetch(32'hBFC00000, 1'b0); chk("rd_w0", b.instr_readdata, 32'h06608424);
        fetch(32'hBFC00004, 1'b0); chk("rd_w1", b.instr_readdata, 32'h0200A524);
        fetch(32'hBFC00008, 1'b0); chk("rd_w2", b.instr_readdata, 32'h0410A400);
        fetch(32'hBFC00010, 1'b0); chk("rd_w4", b.instr_readdata, 32'h00000024);

        // bad fetches and ignored loads in RUN
        fetch(32'hBFC00014, 1'b0); chk("rd_beyond_count", b.instr_readdata, 32'h0);
        b.load_valid = 1'b1; b.load_word = 32'h11223344;
        tick();
        b.load_valid = 1'b0;
        chk("run_load_ignored", 32'(b.load_count), 32'd5);
        fetch(32'hBFC00014, 1'b0); chk("run_no_write", b.instr_readdata, 32'h0);
        fetch(32'h00000000, 1'b1); chk("rd_addr0", b.instr_readdata, 32'h0);
        tick();
        chk("addr0_no_fault", 32'(b.addr_fault), 32'd0);
        chk("addr0_active_no_done", 32'(b.done), 32'd0);
        fetch(32'hBFC00002, 1'b1); chk("rd_misaligned", b.instr_readdata, 32'h0);
        tick();
        chk("misaligned_fault", 32'(b.addr_fault), 32'd1);
        fetch(32'hBFC00000, 1'b0);
        tick();
        chk("fault_sticky", 32'(b.addr_fault), 32'd1);

        // fetch counting and halt
        chk("fc_before", b.fetch_count, 32'd0);
        b.clk_enable = 1'b0;
        fetch(32'hBFC00000, 1'b1);
        tick();
        chk("fc_clk_enable_low", b.fetch_count, 32'd0);
        b.clk_enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            fetch(32'hBFC00000 + 32'(4 * i), 1'b1);
            tick();
        end
        chk("fc_three", b.fetch_count, 32'd3);
        chk("fc_no_done_yet", 32'(b.done), 32'd0);
        fetch(32'h00000000, 1'b0);
        tick();
        chk("halt_done", 32'(b.done), 32'd1);
        chk("halt_fc_hold", b.fetch_count, 32'd3);
        fetch(32'hBFC00004, 1'b1);
        tick();
        chk("after_done_fc_hold", b.fetch_count, 32'd3);
        chk("done_sticky", 32'(b.done), 32'd1);

        // DEPTH_WORDS=4 auto-terminate with valid held for six words
        accepted = 0;
        b4.load_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            b4.load_word = 32'h01020304 + 32'(i) * 32'h10101010;
            if (b4.load_ready) accepted++;
            tick();
        end
        b4.load_valid = 1'b0;
        chk("d4_accepted", 32'(accepted), 32'd4);
        chk("d4_load_count", 32'(b4.load_count), 32'd4);
        chk("d4_loaded", 32'(b4.loaded), 32'd1);
        chk("d4_load_ready", 32'(b4.load_ready), 32'd0);
        b4.instr_address = 32'hBFC0000C; #1;
        chk("d4_rd_w3", b4.instr_readdata, 32'h34333231);
        b4.instr_address = 32'hBFC00010; #1;
        chk("d4_rd_past_depth", b4.instr_readdata, 32'h0);

        // reset mid-load, reset colliding with a handshake, then one-word reload
        fetch(32'hBFC00000, 1'b0);
        reset = 1'b1; tick(); reset = 1'b0;
        load1(32'hCAFEF00D, 1'b0);
        load1(32'h12345678, 1'b0);
        chk("mid_load_count", 32'(b.load_count), 32'd2);
        reset = 1'b1;
        load1(32'h0BADBEEF, 1'b1);
        reset = 1'b0;
        chk("mid_reset_count", 32'(b.load_count), 32'd0);
        chk("mid_reset_loaded", 32'(b.loaded), 32'd0);
        chk("mid_reset_ready", 32'(b.load_ready), 32'd1);
        load1(32'hDEADBEEF, 1'b1);
        chk("reload_count", 32'(b.load_count), 32'd1);
        chk("reload_loaded", 32'(b.loaded), 32'd1);
        fetch(32'hBFC00000, 1'b0); chk("reload_w0", b.instr_readdata, 32'hEFBEADDE);
        fetch(32'hBFC00004, 1'b0); chk("reload_stale_masked", b.instr_readdata, 32'h0);
        tick();
        chk("reload_done", 32'(b.done), 32'd0);
        chk("reload_fault", 32'(b.addr_fault), 32'd0);
        chk("reload_fc", b.fetch_count, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
